// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and its lane-alignment helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  typedef logic [3:0] wb_sel_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational; the caller chooses which funct3/offset to present.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output wb_sel_t     sel,
  output logic [31:0] lane_dat,
  output logic [31:0] ext_dat,
  output logic        misaligned
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    sel        = 4'b1111;
    lane_dat   = wdata;
    misaligned = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        sel      = 4'b0001 << off;
        lane_dat = {4{wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        sel        = 4'b0011 << off;
        lane_dat   = {2{wdata[15:0]}};
        misaligned = off[0];
      end
      default: misaligned = (off != 2'b00);
    endcase
  end

  always_comb begin
    case (off)
      2'd0:    rd_byte = rdata[7:0];
      2'd1:    rd_byte = rdata[15:8];
      2'd2:    rd_byte = rdata[23:16];
      default: rd_byte = rdata[31:24];
    endcase
  end

  // Halfwords only land on offsets 0 or 2 once misalignment is excluded.
  assign rd_half = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ext_dat = rdata;
    case (funct3)
      F3_B:    ext_dat = {{24{rd_byte[7]}}, rd_byte};
      F3_BU:   ext_dat = {24'h0, rd_byte};
      F3_H:    ext_dat = {{16{rd_half[15]}}, rd_half};
      F3_HU:   ext_dat = {16'h0, rd_half};
      F3_W:    ext_dat = rdata;
      default: ext_dat = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM stage: runs one Wishbone classic cycle per load/store, stalls the pipe
// while it is outstanding, and returns extended load data to forwarding.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a memory op in EX/MEM; misaligned ops rejected here
// BUS     | cyc/stb asserted, waiting for ack/err or the timeout
// RESP    | one cycle of mem_ack_o/bus_err_o, pipeline released
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output wb_sel_t     wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic [31:0] mem_dat_o,
  output logic [4:0]  mem_rd_o,
  output logic        mem_ack_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  lsu_state_t  state_q, state_d;
  logic [15:0] cnt_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        load_q;

  logic        start, mis_req, term_ok, term_err;
  logic [2:0]  al_funct3;
  logic [1:0]  al_off;
  wb_sel_t     al_sel;
  logic [31:0] al_lane_dat, al_ext_dat;
  logic        al_misaligned;

  // The request side needs the live EX/MEM fields; the response side needs
  // the fields latched when the bus cycle started.
  assign al_funct3 = (state_q == ST_IDLE) ? funct3_i    : funct3_q;
  assign al_off    = (state_q == ST_IDLE) ? addr_i[1:0] : off_q;

  lsu_align u_align (
    .funct3     (al_funct3),
    .off        (al_off),
    .wdata      (wdata_i),
    .rdata      (wbm_dat_i),
    .sel        (al_sel),
    .lane_dat   (al_lane_dat),
    .ext_dat    (al_ext_dat),
    .misaligned (al_misaligned)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    stall_o  = 1'b0;
    start    = 1'b0;
    mis_req  = 1'b0;
    term_ok  = 1'b0;
    term_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          if (al_misaligned) begin
            mis_req = 1'b1;
          end else begin
            start   = 1'b1;
            stall_o = 1'b1;
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        stall_o = 1'b1;
        // err beats ack; ack beats the timeout on the same cycle
        if (wbm_err_i)              term_err = 1'b1;
        else if (wbm_ack_i)         term_ok  = 1'b1;
        else if (cnt_q == CNT_LAST) term_err = 1'b1;
        if (term_ok || term_err) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wbm_adr_o    <= '0;
      wbm_dat_o    <= '0;
      wbm_sel_o    <= '0;
      wbm_we_o     <= 1'b0;
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
      mem_dat_o    <= '0;
      mem_rd_o     <= '0;
      mem_ack_o    <= 1'b0;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
      cnt_q        <= '0;
      funct3_q     <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      load_q       <= 1'b0;
    end else begin
      misaligned_o <= mis_req;
      mem_ack_o    <= term_ok;
      bus_err_o    <= term_err;
      if (start) begin
        wbm_adr_o <= {addr_i[31:2], 2'b00};
        wbm_dat_o <= al_lane_dat;
        wbm_sel_o <= al_sel;
        wbm_we_o  <= is_store_i;
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        cnt_q     <= '0;
        funct3_q  <= funct3_i;
        off_q     <= addr_i[1:0];
        rd_q      <= rd_i;
        load_q    <= is_load_i;
      end else if (state_q == ST_BUS) begin
        cnt_q <= cnt_q + 16'd1;
        if (term_ok || term_err) begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
        end
        if (term_ok && load_q) begin
          mem_dat_o <= al_ext_dat;
          mem_rd_o  <= rd_q;
        end
      end
    end
  end

endmodule
